// File: rtl/addsub_pkg.sv
// Shared types and helpers for the serial add/subtract unit.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } addsub_state_t;

    localparam logic AS_ADD = 1'b0;
    localparam logic AS_SUB = 1'b1;

    // Widest result the saturation helper can describe.
    localparam int unsigned SAT_MAX_WIDTH = 64;

    // Saturation pattern for a result of the given width.
    // neg=1 -> most negative value, neg=0 -> most positive value.
    // Only the low 'width' bits are meaningful; the rest are zero.
    function automatic logic [SAT_MAX_WIDTH-1:0] sat_value(input logic neg, input int unsigned width);
        logic [SAT_MAX_WIDTH-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < SAT_MAX_WIDTH; i++) begin
            if (i + 1 < width) begin
                v[i] = ~neg;
            end else if (i + 1 == width) begin
                v[i] = neg;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple-carry slice used once per clock by the serial unit.
module addsub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);

    logic [DIGIT:0] carry;

    assign carry[0] = cin;

    // One full adder per bit, chained LSB to MSB.
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
        assign sum[gi]     = x[gi] ^ y[gi] ^ carry[gi];
        assign carry[gi+1] = (x[gi] & y[gi]) | (carry[gi] & (x[gi] ^ y[gi]));
    end

    assign cout = carry[DIGIT];

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle two's-complement adder/subtractor. Operands are consumed LSB-first,
// DIGIT bits per clock, through a single ripple slice. Signed overflow flag and
// optional saturation are applied when the last slice has been accumulated.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             as,
    input  logic             sat,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ov,
    output logic             zero
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG + 1);

    if ((WIDTH % DIGIT) != 0 || WIDTH < 2 || WIDTH > int'(SAT_MAX_WIDTH)) begin : g_param_check
        $error("addsub_serial: WIDTH must be in 2..64 and a multiple of DIGIT");
    end

    addsub_state_t    state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] bx_reg;
    logic [WIDTH-1:0] res_reg;
    logic             carry_reg;
    logic             sat_reg;
    logic             a_msb_reg;
    logic             bx_msb_reg;
    logic [CW-1:0]    cnt_reg;

    logic [DIGIT-1:0] slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] res_next;
    logic             ov_raw;
    logic [WIDTH-1:0] s_final;

    addsub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .x    (a_reg[DIGIT-1:0]),
        .y    (bx_reg[DIGIT-1:0]),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // New slice enters the result register from the top so that after NDIG
    // slices the LSB slice has reached bit 0.
    if (NDIG == 1) begin : g_res_single
        assign res_next = slice_sum;
    end else begin : g_res_multi
        assign res_next = {slice_sum, res_reg[WIDTH-1:DIGIT]};
    end

    // Signed overflow and optional saturation of the completed raw sum.
    always_comb begin
        ov_raw  = (a_msb_reg == bx_msb_reg) && (res_reg[WIDTH-1] != a_msb_reg);
        s_final = res_reg;
        if (sat_reg && ov_raw) begin
            s_final = WIDTH'(sat_value(a_msb_reg, WIDTH));
        end
    end

    // Control FSM, operand/result shift registers and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_reg      <= '0;
            bx_reg     <= '0;
            res_reg    <= '0;
            carry_reg  <= 1'b0;
            sat_reg    <= 1'b0;
            a_msb_reg  <= 1'b0;
            bx_msb_reg <= 1'b0;
            cnt_reg    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            s          <= '0;
            cout       <= 1'b0;
            ov         <= 1'b0;
            zero       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtraction is A + ~B + 1: invert B here, inject the +1 as carry-in.
                        a_reg      <= a;
                        bx_reg     <= b ^ {WIDTH{as}};
                        carry_reg  <= (as == AS_SUB);
                        sat_reg    <= sat;
                        a_msb_reg  <= a[WIDTH-1];
                        bx_msb_reg <= b[WIDTH-1] ^ as;
                        cnt_reg    <= '0;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    a_reg     <= a_reg >> DIGIT;
                    bx_reg    <= bx_reg >> DIGIT;
                    res_reg   <= res_next;
                    carry_reg <= slice_cout;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(NDIG - 1)) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    s     <= s_final;
                    cout  <= carry_reg;
                    ov    <= ov_raw;
                    zero  <= (s_final == '0);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: three instances (DIGIT = 1, 4, 16) driven in parallel,
// directed corner cases, protocol cases on the DIGIT=4 unit, and random regression
// against a plain-arithmetic reference model.
module tb_addsub_serial;

    localparam int W = 16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic        as;
    logic        sat;

    logic [2:0]   busy_v;
    logic [2:0]   done_v;
    logic [2:0]   cout_v;
    logic [2:0]   ov_v;
    logic [2:0]   zero_v;
    logic [W-1:0] s_v [3];

    int n_checks = 0;
    int n_errors = 0;

    addsub_serial #(.WIDTH(W), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .as(as), .sat(sat),
        .busy(busy_v[0]), .done(done_v[0]), .s(s_v[0]), .cout(cout_v[0]), .ov(ov_v[0]), .zero(zero_v[0])
    );

    addsub_serial #(.WIDTH(W), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .as(as), .sat(sat),
        .busy(busy_v[1]), .done(done_v[1]), .s(s_v[1]), .cout(cout_v[1]), .ov(ov_v[1]), .zero(zero_v[1])
    );

    addsub_serial #(.WIDTH(W), .DIGIT(16)) u_d16 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .as(as), .sat(sat),
        .busy(busy_v[2]), .done(done_v[2]), .s(s_v[2]), .cout(cout_v[2]), .ov(ov_v[2]), .zero(zero_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ndig(input int idx);
        case (idx)
            0:       return 16;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: true signed result from integer arithmetic, carry from unsigned compare/sum.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic m_as,
                         input logic m_sat, output logic [W-1:0] es, output logic ec, output logic eo);
        int          sa;
        int          sb;
        int          t;
        logic [W:0]  usum;
        sa   = $signed(ma);
        sb   = $signed(mb);
        t    = m_as ? (sa - sb) : (sa + sb);
        eo   = (t > 32767) || (t < -32768);
        usum = {1'b0, ma} + {1'b0, mb};
        ec   = m_as ? (ma >= mb) : usum[W];
        if (m_sat && eo) es = (t < 0) ? 16'h8000 : 16'h7FFF;
        else             es = t[W-1:0];
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Count edges until done on instance idx; expired budget counts as a failure.
    task automatic wait_done(input int idx, input int max_edges, output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!done_v[idx] && edges < max_edges);
        if (!done_v[idx]) check($sformatf("done_timeout_i%0d", idx), 32'(done_v[idx]), 32'd1);
    endtask

    // One operation on all three instances, checked against the model.
    task automatic do_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                         input logic o_as, input logic o_sat);
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
        logic [2:0]   got;
        int           lat [3];
        int           bcnt [3];
        logic [W-1:0] s0 [3];
        logic [2:0]   held;
        logic [W-1:0] rs [3];
        logic [2:0]   rc;
        logic [2:0]   ro;
        logic [2:0]   rz;
        model(oa, ob, o_as, o_sat, es, ec, eo);
        @(negedge clk);
        a = oa; b = ob; as = o_as; sat = o_sat; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); as = 1'($urandom); sat = 1'($urandom);
        got = '0;
        held = '1;
        for (int i = 0; i < 3; i++) begin
            lat[i]  = -1;
            bcnt[i] = busy_v[i] ? 1 : 0;
            s0[i]   = s_v[i];
        end
        for (int k = 1; k <= 40 && got != 3'b111; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (!got[i]) begin
                    if (busy_v[i]) bcnt[i]++;
                    if (done_v[i]) begin
                        got[i] = 1'b1;
                        lat[i] = k;
                        rs[i] = s_v[i]; rc[i] = cout_v[i]; ro[i] = ov_v[i]; rz[i] = zero_v[i];
                    end else if (s_v[i] !== s0[i]) begin
                        held[i] = 1'b0;
                    end
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_done_i%0d", tag, i), 32'(got[i]), 32'd1);
            if (got[i]) begin
                check($sformatf("%s_lat_i%0d", tag, i), 32'(lat[i]), 32'(ndig(i) + 1));
                check($sformatf("%s_busy_i%0d", tag, i), 32'(bcnt[i]), 32'(ndig(i) + 1));
                check($sformatf("%s_hold_i%0d", tag, i), 32'(held[i]), 32'd1);
                check($sformatf("%s_s_i%0d", tag, i), 32'(rs[i]), 32'(es));
                check($sformatf("%s_cout_i%0d", tag, i), 32'(rc[i]), 32'(ec));
                check($sformatf("%s_ov_i%0d", tag, i), 32'(ro[i]), 32'(eo));
                check($sformatf("%s_zero_i%0d", tag, i), 32'(rz[i]), 32'(es == 16'h0000));
            end
        end
    endtask

    logic [W-1:0] corners [4];

    initial begin
        int e;
        int e2;
        int extra;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        corners[0] = 16'h0000; corners[1] = 16'h7FFF; corners[2] = 16'h8000; corners[3] = 16'hFFFF;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; as = 1'b0; sat = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_busy_i%0d", i), 32'(busy_v[i]), 32'd0);
            check($sformatf("rst_done_i%0d", i), 32'(done_v[i]), 32'd0);
            check($sformatf("rst_s_i%0d", i), 32'(s_v[i]), 32'd0);
            check($sformatf("rst_flags_i%0d", i), 32'({cout_v[i], ov_v[i], zero_v[i]}), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        do_op("add_1234_0fff", 16'h1234, 16'h0FFF, 1'b0, 1'b0);
        do_op("sub_5_7",       16'h0005, 16'h0007, 1'b1, 1'b0);
        do_op("sub_eq",        16'h1234, 16'h1234, 1'b1, 1'b0);
        do_op("add_ovf",       16'h7FFF, 16'h0001, 1'b0, 1'b0);
        do_op("add_ovf_sat",   16'h7FFF, 16'h0001, 1'b0, 1'b1);
        do_op("sub_ovf",       16'h8000, 16'h0001, 1'b1, 1'b0);
        do_op("sub_ovf_sat",   16'h8000, 16'h0001, 1'b1, 1'b1);
        do_op("add_wrap",      16'hFFFF, 16'h0001, 1'b0, 1'b0);

        // start pulsed while busy is ignored (DIGIT=4 instance)
        pulse_reset();
        @(negedge clk);
        a = 16'h1234; b = 16'h0FFF; as = 1'b0; sat = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        a = 16'h0001; b = 16'h0001; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done(1, 20, e);
        check("busy_start_lat", 32'(e + 3), 32'd5);
        check("busy_start_s", 32'(s_v[1]), 32'h2233);
        extra = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done_v[1]) extra++;
        end
        check("busy_start_no_extra_done", 32'(extra), 32'd0);
        check("busy_start_s_kept", 32'(s_v[1]), 32'h2233);

        // start held in the done cycle is accepted
        pulse_reset();
        @(negedge clk);
        a = 16'h0005; b = 16'h0007; as = 1'b1; sat = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done(1, 20, e);
        check("b2b_first_lat", 32'(e), 32'd5);
        check("b2b_first_s", 32'(s_v[1]), 32'hFFFE);
        check("b2b_first_cout", 32'(cout_v[1]), 32'd0);
        a = 16'h7FFF; b = 16'h0001; as = 1'b0; sat = 1'b1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done(1, 20, e2);
        check("b2b_second_gap", 32'(e2 + 1), 32'd6);
        check("b2b_second_s", 32'(s_v[1]), 32'h7FFF);
        check("b2b_second_ov", 32'(ov_v[1]), 32'd1);

        // reset mid-RUN aborts the operation
        pulse_reset();
        do_op("pre_abort", 16'h1234, 16'h0FFF, 1'b0, 1'b0);
        @(negedge clk);
        a = 16'h0F0F; b = 16'h0101; as = 1'b0; sat = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_s", 32'(s_v[1]), 32'd0);
        check("abort_busy", 32'(busy_v[1]), 32'd0);
        check("abort_flags", 32'({done_v[1], cout_v[1], ov_v[1], zero_v[1]}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done_v[1]) extra++;
        end
        check("abort_no_done", 32'(extra), 32'd0);
        do_op("post_abort", 16'h0F0F, 16'h0101, 1'b0, 1'b0);

        // Random regression on all three slice widths
        for (int n = 0; n < 50; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
            do_op($sformatf("rnd%0d", n), ra, rb, 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
